// File: rtl/gray_ptr_receiver.sv
// Reader side of a Gray-coded pointer crossing: synchronizes a remote Gray
// count, decodes it, and reports the per-sample advance and backward moves.
module gray_ptr_receiver #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_gray_sync,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_adv,
    output logic [WIDTH-1:0] o_delta,
    output logic             o_err
);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    localparam logic [WIDTH-1:0] BIN_RST = g2b(RESET_VALUE);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_delta;
    logic             r_adv;
    logic             r_err;

    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_delta;
    logic             w_back;

    // sync[0] takes the raw bus; no logic may sit ahead of it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= i_gray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_nb    = g2b(r_sync[SYNC_STAGES-1]);
    assign w_delta = w_nb - r_bin;
    // Deltas in the upper half of the ring can only be a backward move.
    assign w_back  = w_delta[WIDTH-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin   <= BIN_RST;
            r_delta <= '0;
            r_adv   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_bin   <= w_nb;
            r_delta <= w_delta;
            r_adv   <= (w_nb != r_bin);
            if (w_back) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_gray_sync = r_sync[SYNC_STAGES-1];
    assign o_bin       = r_bin;
    assign o_delta     = r_delta;
    assign o_adv       = r_adv;
    assign o_err       = r_err;

endmodule

// File: doc/gray_ptr_receiver.md
# gray_ptr_receiver

Receiving end of a Gray-coded pointer crossing: takes a Gray count produced by a remote `gray_counter` in another clock domain and synchronizes it into the local clock. It decodes the count to binary and reports how far the remote pointer advanced since the previous sample. It also flags illegal backward movement. It is the reader-side companion used by async FIFO and credit-return paths in the NoC.

## Interface
- `WIDTH`, default 4: pointer width in bits; must be at least 2.
- `SYNC_STAGES`, default 2: number of synchronizer flops; must be at least 2.
- `RESET_VALUE`, default 0: Gray value loaded into the synchronizer; it must match the remote counter's reset value.
- `i_clk` in 1: local clock; the block uses this one clock only.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_gray` in WIDTH: remote Gray pointer, asynchronous to `i_clk`.
- `i_err_clr` in 1: clears the sticky `o_err` flag.
- `o_gray_sync` out WIDTH: output of the last synchronizer stage.
- `o_bin` out WIDTH: registered binary decode of `o_gray_sync`.
- `o_adv` out 1: one-cycle pulse when `o_bin` changes value.
- `o_delta` out WIDTH: registered advance since the previous sample, computed mod 2^WIDTH; 0 when the pointer has not moved.
- `o_err` out 1: sticky flag; set when the pointer moves backward.

## Operation
- Synchronizer: `sync[0]` samples `i_gray` on every edge, and `sync[k]` samples `sync[k-1]`.
  - `o_gray_sync` = `sync[SYNC_STAGES-1]`.
  - The synchronizer performs no logic on `i_gray` before `sync[0]`.
- Decode: `g2b(g)` gives bit WIDTH-1 = g[WIDTH-1], and bit i = g[i] XOR bit i+1 of the result.
- Each non-reset edge, with `nb = g2b(o_gray_sync)`:
  - `o_bin <= nb`
  - `o_delta <= (nb - o_bin) mod 2^WIDTH`
  - `o_adv <= (nb != o_bin)`
- Multi-step jumps are legal, because the remote clock may be faster.
  - A delta in the range 1 .. 2^(WIDTH-1)-1 is a forward advance.
  - A delta of 2^(WIDTH-1) or more is a backward move or corruption. This sets `o_err` (see Error flag).
- Error flag:
  - `o_err <= 1` when a backward delta is computed.
  - Otherwise `o_err <= 0` if `i_err_clr` is high; otherwise it holds.
  - A set wins over a simultaneous clear.
- Wrap-around: from all-ones binary to 0 is a forward delta of 1, with no error.
- Reset values, applied on any edge where `i_rst` = 1, regardless of other inputs:
  - All `sync[*]` = `RESET_VALUE`, so `o_gray_sync` = `RESET_VALUE`.
  - `o_bin` = `g2b(RESET_VALUE)`.
  - `o_adv` = 0, `o_delta` = 0, `o_err` = 0.
- Reset mid-operation: the whole pipeline reloads.
  - After release, the synchronizer re-samples `i_gray`.
  - If the remote pointer was not also reset, the first valid sample produces one `o_adv` pulse whose `o_delta` equals its distance from `g2b(RESET_VALUE)`. This is intended behaviour.

## Timing
- Counting `i_gray`, when stable before edge 1, as captured at edge 1:
  - `o_gray_sync` reflects it after edge `SYNC_STAGES`.
  - `o_bin`, `o_adv`, `o_delta` and `o_err` reflect it after edge `SYNC_STAGES+1`.
- `o_adv` is high for exactly one cycle per distinct decoded value. A pointer that is held produces no further pulses.
- `i_err_clr` takes effect on the next edge and has single-cycle effect.
- The block has no input handshake and no stall: every cycle produces a new sample.

## Test plan
WIDTH=4, SYNC_STAGES=2, RESET_VALUE=0 unless noted.
- Reset: hold `i_rst` for 3 cycles while toggling `i_gray` -> all outputs 0 throughout. Repeat with RESET_VALUE=4'b1000 -> `o_bin`=15 after reset.
- Single steps: `i_gray` = 0001, 0011, 0010, each held 4 cycles -> `o_bin` = 1, 2, 3, each appearing 3 edges after capture. Each step gives a one-cycle `o_adv` pulse with `o_delta`=1 and `o_err`=0.
- Skip: `i_gray` jumps from 0010 (bin 3) to 0101 (bin 6) -> `o_bin`=6, `o_delta`=3, `o_adv`=1, `o_err`=0.
- Wrap: 1000 (bin 15) to 0000 -> `o_bin`=0, `o_delta`=1, `o_err`=0.
- Backward and clear:
  - 0111 (bin 5) to 0110 (bin 4) -> `o_delta`=15 and `o_err`=1, which holds.
  - `i_err_clr` pulse -> `o_err`=0 next edge.
  - A backward step coinciding with `i_err_clr` -> `o_err` stays 1.
- Reset mid-run: `o_bin`=9 with `i_gray`=1101 held; assert `i_rst` for 1 cycle -> outputs 0 next edge. After release, `o_gray_sync`=1101 after 2 edges, then `o_bin`=9 with one `o_adv` pulse and `o_delta`=9.
